// File: rtl/sprite_fetch_arbiter.sv
// rtl/sprite_fetch_arbiter.sv - round-robin arbiter sharing one palette-index ROM port among four layer fetchers
// Tags each granted read through the fixed ROM latency and routes the returned byte to its requester.
module sprite_fetch_arbiter #(
    parameter int AW     = 19,
    parameter int RD_LAT = 2,
    parameter int NREQ   = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic                 mem_busy,
    output logic [NREQ-1:0]      gnt,
    output logic                 mem_rd,
    output logic [AW-1:0]        mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [7:0]           rsp_data,
    output logic [NREQ-1:0]      pending
);

    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [1:0]              gnt_id_q, gnt_id_d;
    logic                    mem_rd_q, mem_rd_d;
    logic [AW-1:0]           mem_addr_q, mem_addr_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [RD_LAT-1:0]       tv_q, tv_d;
    logic [RD_LAT-1:0][1:0]  tid_q, tid_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_data_q, rsp_data_d;
    logic [NREQ-1:0]         pending_q, pending_d;

    logic [NREQ-1:0]         eligible;
    logic                    found;
    logic                    grant;
    logic [1:0]              pick;

    always_comb begin
        eligible = req & ~pending_q & ~gnt_q;
        found    = 1'b0;
        pick     = ptr_q;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && eligible[ptr_q + 2'(off)]) begin
                found = 1'b1;
                pick  = ptr_q + 2'(off);
            end
        end
        grant = found & ~mem_busy;

        gnt_d      = grant ? (NREQ'(1) << pick) : '0;
        gnt_id_d   = pick;
        mem_rd_d   = grant;
        mem_addr_d = grant ? req_addr[int'(pick)*AW +: AW] : mem_addr_q;
        ptr_d      = grant ? pick + 2'd1 : ptr_q;

        // Stage 0 captures the read issued this cycle; older stages shift toward the ROM data return.
        tv_d     = '0;
        tid_d    = '0;
        tv_d[0]  = mem_rd_q;
        tid_d[0] = gnt_id_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tv_d[i]  = tv_q[i-1];
            tid_d[i] = tid_q[i-1];
        end

        rsp_valid_d = tv_q[RD_LAT-1] ? (NREQ'(1) << tid_q[RD_LAT-1]) : '0;
        rsp_data_d  = tv_q[RD_LAT-1] ? mem_rdata : rsp_data_q;

        // Pending drops in the same cycle the response is presented.
        pending_d = (pending_q | gnt_q) & ~rsp_valid_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            ptr_q       <= '0;
            tv_q        <= '0;
            tid_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            pending_q   <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            ptr_q       <= ptr_d;
            tv_q        <= tv_d;
            tid_q       <= tid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            pending_q   <= pending_d;
        end
    end

    assign gnt       = gnt_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb/tb_sprite_fetch_arbiter.sv - directed self-checking bench for sprite_fetch_arbiter
// Three instances with RD_LAT 1, 2 and 4 share the stimulus.
module tb_sprite_fetch_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  req;
    logic [75:0] req_addr;
    logic        mem_busy;
    logic [7:0]  mem_rdata;

    logic [3:0]  gnt_1, gnt_2, gnt_4;
    logic        mem_rd_1, mem_rd_2, mem_rd_4;
    logic [18:0] mem_addr_1, mem_addr_2, mem_addr_4;
    logic [3:0]  rsp_valid_1, rsp_valid_2, rsp_valid_4;
    logic [7:0]  rsp_data_1, rsp_data_2, rsp_data_4;
    logic [3:0]  pending_1, pending_2, pending_4;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    sprite_fetch_arbiter #(.AW(19), .RD_LAT(1), .NREQ(4)) u_lat1 (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .mem_busy(mem_busy),
        .gnt(gnt_1), .mem_rd(mem_rd_1), .mem_addr(mem_addr_1), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1), .pending(pending_1));

    sprite_fetch_arbiter #(.AW(19), .RD_LAT(2), .NREQ(4)) u_lat2 (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .mem_busy(mem_busy),
        .gnt(gnt_2), .mem_rd(mem_rd_2), .mem_addr(mem_addr_2), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid_2), .rsp_data(rsp_data_2), .pending(pending_2));

    sprite_fetch_arbiter #(.AW(19), .RD_LAT(4), .NREQ(4)) u_lat4 (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .mem_busy(mem_busy),
        .gnt(gnt_4), .mem_rd(mem_rd_4), .mem_addr(mem_addr_4), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid_4), .rsp_data(rsp_data_4), .pending(pending_4));

    initial forever #5 Clk = ~Clk;

    // ROM data changes every cycle so the captured byte identifies the sampling cycle.
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        mem_rdata = 8'hA0 + 8'(cyc);
    endtask

    task automatic set_addr(input int i, input logic [18:0] a);
        req_addr[i*19 +: 19] = a;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        req       = '0;
        req_addr  = '0;
        mem_busy  = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        check("rst gnt",       32'(gnt_2),       0);
        check("rst mem_rd",    32'(mem_rd_2),    0);
        check("rst mem_addr",  32'(mem_addr_2),  0);
        check("rst rsp_valid", 32'(rsp_valid_2), 0);
        check("rst rsp_data",  32'(rsp_data_2),  0);
        check("rst pending",   32'(pending_2),   0);
        Reset = 1'b0;

        // Single read on all three latencies.
        req = 4'b0001;
        set_addr(0, 19'h00123);
        tick();
        check("t1 gnt",       32'(gnt_2),      32'h1);
        check("t1 mem_rd",    32'(mem_rd_2),   32'h1);
        check("t1 mem_addr",  32'(mem_addr_2), 32'h00123);
        check("t1 gnt lat1",  32'(gnt_1),      32'h1);
        check("t1 gnt lat4",  32'(gnt_4),      32'h1);
        req = 4'b0000;
        for (int c = 1; c <= 7; c++) begin
            check("t1 rsp lat1", 32'(rsp_valid_1), (c == 3) ? 32'h1 : 32'h0);
            check("t1 rsp lat2", 32'(rsp_valid_2), (c == 4) ? 32'h1 : 32'h0);
            check("t1 rsp lat4", 32'(rsp_valid_4), (c == 6) ? 32'h1 : 32'h0);
            check("t1 pending",  32'(pending_2),   (c == 2 || c == 3) ? 32'h1 : 32'h0);
            if (c == 3) check("t1 data lat1", 32'(rsp_data_1), 32'(8'(8'hA0 + cyc - 1)));
            if (c == 4) check("t1 data lat2", 32'(rsp_data_2), 32'(8'(8'hA0 + cyc - 1)));
            if (c == 6) check("t1 data lat4", 32'(rsp_data_4), 32'(8'(8'hA0 + cyc - 1)));
            tick();
        end

        // Fairness with all four requesting continuously.
        Reset = 1'b1;
        tick();
        check("t2 rst gnt",     32'(gnt_2),     0);
        check("t2 rst pending", 32'(pending_2), 0);
        Reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 19'(32'h10000 + i));
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("t2 gnt",  32'(gnt_2),      32'(1 << ((c - 1) % 4)));
            check("t2 addr", 32'(mem_addr_2), 32'h10000 + 32'((c - 1) % 4));
            if (c >= 4) check("t2 rsp", 32'(rsp_valid_2), 32'(1 << ((c - 4) % 4)));
        end
        req = 4'b0000;
        repeat (4) tick();
        check("t2 drained", 32'(pending_2), 0);

        // Rotation: grant to 1 leaves the pointer at 2.
        req = 4'b0010;
        set_addr(1, 19'h2AAAA);
        tick();
        check("t3 gnt1", 32'(gnt_2),      32'h2);
        check("t3 addr1", 32'(mem_addr_2), 32'h2AAAA);
        req = 4'b1011;
        set_addr(0, 19'h30000);
        set_addr(3, 19'h33333);
        tick();
        check("t3 gnt3",  32'(gnt_2),      32'h8);
        check("t3 addr3", 32'(mem_addr_2), 32'h33333);
        req = 4'b0011;
        tick();
        check("t3 gnt0",  32'(gnt_2),      32'h1);
        check("t3 addr0", 32'(mem_addr_2), 32'h30000);
        req = 4'b0010;
        tick();
        check("t3 gap gnt", 32'(gnt_2),       0);
        check("t3 gap rd",  32'(mem_rd_2),    0);
        check("t3 rsp1",    32'(rsp_valid_2), 32'h2);
        tick();
        check("t3 regnt1", 32'(gnt_2),      32'h2);
        check("t3 readdr", 32'(mem_addr_2), 32'h2AAAA);
        req = 4'b0000;
        repeat (4) tick();

        // mem_busy stalls granting but not in-flight responses.
        req = 4'b1000;
        set_addr(3, 19'h4BCDE);
        tick();
        check("t4 gnt3", 32'(gnt_2), 32'h8);
        req = 4'b0110;
        mem_busy = 1'b1;
        set_addr(1, 19'h51111);
        set_addr(2, 19'h52222);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4 busy gnt",  32'(gnt_2),      0);
            check("t4 busy rd",   32'(mem_rd_2),   0);
            check("t4 busy addr", 32'(mem_addr_2), 32'h4BCDE);
        end
        check("t4 rsp3",  32'(rsp_valid_2), 32'h8);
        check("t4 data3", 32'(rsp_data_2),  32'(8'(8'hA0 + cyc - 1)));
        mem_busy = 1'b0;
        tick();
        check("t4 resume gnt",  32'(gnt_2),      32'h2);
        check("t4 resume addr", 32'(mem_addr_2), 32'h51111);
        req = 4'b0100;
        tick();
        check("t4 gnt2", 32'(gnt_2), 32'h4);
        req = 4'b0000;
        repeat (4) tick();

        // Reset while a read is in flight.
        req = 4'b0100;
        set_addr(2, 19'h6CAFE);
        tick();
        check("t5 gnt2", 32'(gnt_2), 32'h4);
        req = 4'b0000;
        Reset = 1'b1;
        tick();
        check("t5 rst gnt",     32'(gnt_2),       0);
        check("t5 rst rd",      32'(mem_rd_2),    0);
        check("t5 rst addr",    32'(mem_addr_2),  0);
        check("t5 rst rsp",     32'(rsp_valid_2), 0);
        check("t5 rst data",    32'(rsp_data_2),  0);
        check("t5 rst pending", 32'(pending_2),   0);
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t5 no rsp",     32'(rsp_valid_2), 0);
            check("t5 no pending", 32'(pending_2),   0);
        end
        req = 4'b1100;
        set_addr(3, 19'h7BEEF);
        tick();
        check("t5 regnt2", 32'(gnt_2),      32'h4);
        check("t5 readdr", 32'(mem_addr_2), 32'h6CAFE);
        req = 4'b1000;
        tick();
        check("t5 gnt3", 32'(gnt_2), 32'h8);
        req = 4'b0000;
        tick();
        tick();
        check("t5 rsp2",  32'(rsp_valid_2), 32'h4);
        check("t5 data2", 32'(rsp_data_2),  32'(8'(8'hA0 + cyc - 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
